// File: rtl/wave_display_reader_pkg.sv
// Shared widths, trace-window geometry and FSM encodings for the wave RAM read side.
package wave_display_reader_pkg;

  localparam int ADDR_WIDTH   = 9;
  localparam int SAMPLE_WIDTH = 8;
  localparam int X_WIDTH      = 11;
  localparam int Y_WIDTH      = 10;

  localparam logic [Y_WIDTH-1:0] Y_TOP      = 10'd112;
  localparam logic [Y_WIDTH-1:0] Y_BOTTOM   = Y_TOP + 10'd255;
  localparam logic [Y_WIDTH-1:0] LAST_LINE  = 10'd479;
  localparam logic [X_WIDTH-1:0] LAST_X     = 11'd639;
  localparam logic [X_WIDTH-1:0] TRACE_COLS = 11'd512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sample value that maps onto screen line y; the window bottom reads as 0.
  function automatic logic [SAMPLE_WIDTH-1:0] traceLine(input logic [Y_WIDTH-1:0] y);
    return SAMPLE_WIDTH'(Y_BOTTOM - y);
  endfunction

  function automatic logic inWindow(input logic [Y_WIDTH-1:0] y);
    return (y >= Y_TOP) && (y <= Y_BOTTOM);
  endfunction

endpackage

// File: rtl/wave_display_reader_span_compare.sv
// Combinational test: does trace line ty fall between two adjacent samples (inclusive)?
module wave_span_compare
  import wave_display_reader_pkg::*;
(
  input  logic [SAMPLE_WIDTH-1:0] prev_i,
  input  logic [SAMPLE_WIDTH-1:0] cur_i,
  input  logic [SAMPLE_WIDTH-1:0] ty_i,
  output logic                    hit_o
);

  logic [SAMPLE_WIDTH-1:0] spanLo;
  logic [SAMPLE_WIDTH-1:0] spanHi;

  always_comb begin
    spanLo = (prev_i < cur_i) ? prev_i : cur_i;
    spanHi = (prev_i < cur_i) ? cur_i : prev_i;
  end

  assign hit_o = (ty_i >= spanLo) && (ty_i <= spanHi);

endmodule

// File: rtl/wave_display_reader.sv
// Read side of the double-buffered wave RAM: scans the readable half alongside the VGA stream.
// The grid overlay is built only when WAVE_DISPLAY_GRID_EN is defined.
module wave_display_reader
  import wave_display_reader_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    frame_start_i,
  input  logic                    read_index_i,
  input  logic [X_WIDTH-1:0]      x_i,
  input  logic [Y_WIDTH-1:0]      y_i,
  input  logic                    pixel_valid_i,
  input  logic [SAMPLE_WIDTH-1:0] read_value_i,
  output logic [ADDR_WIDTH-1:0]   read_address_o,
  output logic                    valid_out_o,
  output logic                    wave_pixel_o,
  output logic                    grid_pixel_o,
  output logic                    wave_display_idle_o
);

  state_e state_q, state_d;
  logic   activeHalf_q, activeHalf_d;
  logic   idlePulse;

  logic [ADDR_WIDTH-1:0]   readAddr_q;
  logic                    valid1_q, draw1_q, inWin1_q;
  logic                    traceCol1_q, firstCol1_q, evenCol1_q;
  logic [SAMPLE_WIDTH-1:0] ty1_q;

  logic [SAMPLE_WIDTH-1:0] prevSample_q;
  logic [SAMPLE_WIDTH-1:0] spanPrev;
  logic                    validOut_q, wavePixel_q;
  logic                    spanHit, traceVis, pixelInTrace;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      activeHalf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      activeHalf_q <= activeHalf_d;
    end
  end

  // A new frame_start always wins, so an aborted frame never produces an idle pulse.
  always_comb begin
    state_d      = state_q;
    activeHalf_d = activeHalf_q;
    idlePulse    = 1'b0;
    case (state_q)
      DRAW: begin
        if (pixel_valid_i && (y_i == LAST_LINE) && (x_i == LAST_X)) state_d = DONE;
      end
      DONE: begin
        state_d   = IDLE;
        idlePulse = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (frame_start_i) begin
      state_d      = DRAW;
      activeHalf_d = read_index_i;
    end
  end

  assign pixelInTrace = (x_i < TRACE_COLS);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      readAddr_q  <= '0;
      valid1_q    <= 1'b0;
      draw1_q     <= 1'b0;
      inWin1_q    <= 1'b0;
      traceCol1_q <= 1'b0;
      firstCol1_q <= 1'b0;
      evenCol1_q  <= 1'b0;
      ty1_q       <= '0;
    end else begin
      valid1_q    <= pixel_valid_i;
      draw1_q     <= (state_q == DRAW);
      inWin1_q    <= inWindow(y_i);
      traceCol1_q <= pixelInTrace;
      firstCol1_q <= (x_i == '0);
      evenCol1_q  <= ~x_i[0];
      ty1_q       <= traceLine(y_i);
      if (pixel_valid_i && pixelInTrace) readAddr_q <= {activeHalf_q, x_i[ADDR_WIDTH-1:1]};
    end
  end

  // Column 0 compares the sample with itself so the trace never joins across line ends.
  assign spanPrev = firstCol1_q ? read_value_i : prevSample_q;
  assign traceVis = valid1_q && inWin1_q && traceCol1_q;

  wave_span_compare u_span (
    .prev_i (spanPrev),
    .cur_i  (read_value_i),
    .ty_i   (ty1_q),
    .hit_o  (spanHit)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      prevSample_q <= '0;
      validOut_q   <= 1'b0;
      wavePixel_q  <= 1'b0;
    end else begin
      validOut_q  <= valid1_q;
      wavePixel_q <= traceVis && draw1_q && spanHit;
      if (valid1_q && traceCol1_q && evenCol1_q) prevSample_q <= read_value_i;
    end
  end

`ifdef WAVE_DISPLAY_GRID_EN
  logic gridCol1_q, gridPixel_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      gridCol1_q  <= 1'b0;
      gridPixel_q <= 1'b0;
    end else begin
      gridCol1_q  <= (x_i[4:0] == 5'd0);
      gridPixel_q <= traceVis && (gridCol1_q || (ty1_q[4:0] == 5'd0));
    end
  end

  assign grid_pixel_o = gridPixel_q;
`else
  assign grid_pixel_o = 1'b0;
`endif

  assign read_address_o      = readAddr_q;
  assign valid_out_o         = validOut_q;
  assign wave_pixel_o        = wavePixel_q;
  assign wave_display_idle_o = idlePulse;

endmodule
